// File: rtl/logic_loom.sv
// Parallel-in / serial-out shift register: load a WIDTH-bit word, then stream it
// out one bit per clock while shift is held, filling the vacated end with FILL_BIT.
module logic_loom #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit FILL_BIT  = 1'b0
) (
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             shift,
  input  logic             clk,
  output logic             out,
  input  logic             rst_n
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;

  // Direction is fixed at elaboration: the shift path and the tap move together.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {sreg[WIDTH-2:0], FILL_BIT};
      assign out     = sreg[WIDTH-1];
    end else begin : g_lsb
      assign shifted = {FILL_BIT, sreg[WIDTH-1:1]};
      assign out     = sreg[0];
    end
  endgenerate

  // Load outranks shift so a new word can start on the same edge as the last shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sreg <= '0;
    else if (load)  sreg <= din;
    else if (shift) sreg <= shifted;
  end

endmodule

// File: tb/tb_logic_loom.sv
// Bench for logic_loom (WIDTH=4, MSB first, fill 0): vector table through a
// scoreboard queue, plus hand-written async-reset sequences.
module tb_logic_loom;

  logic [3:0] din;
  logic       load, shift, clk, rst_n;
  logic       out;

  logic_loom #(.WIDTH(4), .MSB_FIRST(1'b1), .FILL_BIT(1'b0)) dut (
    .din(din), .load(load), .shift(shift), .clk(clk), .out(out), .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] din;
    logic       load;
    logic       shift;
    logic       exp_out;
    string      name;
  } vec_t;

  typedef struct {
    logic  exp_out;
    string name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void addv(logic [3:0] d, logic l, logic s, logic e, string n);
    vec_t v;
    v.din = d; v.load = l; v.shift = s; v.exp_out = e; v.name = n;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: out=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, push the expectation, compare 1ns after the rising edge.
  task automatic apply(vec_t v);
    sb_t e;
    @(negedge clk);
    din = v.din; load = v.load; shift = v.shift;
    e.exp_out = v.exp_out; e.name = v.name;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = sbq.pop_front();
      check(e.name, out, e.exp_out);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    din = 4'b0; load = 1'b0; shift = 1'b0; rst_n = 1'b0;

    // Test 2: load 1001, shift x3 -> 1,0,0,1
    addv(4'b1001, 1, 0, 1, "t2_load");
    addv(4'b0000, 0, 1, 0, "t2_sh1");
    addv(4'b0000, 0, 1, 0, "t2_sh2");
    addv(4'b0000, 0, 1, 1, "t2_sh3");
    // Test 3: load,shift,load,shift,shift,load
    addv(4'b1001, 1, 0, 1, "t3_l1");
    addv(4'b1001, 0, 1, 0, "t3_s1");
    addv(4'b1001, 1, 0, 1, "t3_l2");
    addv(4'b1001, 0, 1, 0, "t3_s2");
    addv(4'b1001, 0, 1, 0, "t3_s3");
    addv(4'b1001, 1, 0, 1, "t3_l3");
    // Test 4: load wins over shift; following shift proves sreg=1001
    addv(4'b0000, 0, 0, 1, "t4_pre");
    addv(4'b1001, 1, 1, 1, "t4_both");
    addv(4'b0000, 0, 1, 0, "t4_after");
    // Test 5: hold 0110 (din toggled with load=0 must be ignored), then shift x5
    addv(4'b0110, 1, 0, 0, "t5_load");
    addv(4'b1111, 0, 0, 0, "t5_hold1");
    addv(4'b1000, 0, 0, 0, "t5_hold2");
    addv(4'b1111, 0, 0, 0, "t5_hold3");
    addv(4'b0000, 0, 1, 1, "t5_sh1");
    addv(4'b0000, 0, 1, 1, "t5_sh2");
    addv(4'b0000, 0, 1, 0, "t5_sh3");
    addv(4'b0000, 0, 1, 0, "t5_sh4");
    addv(4'b0000, 0, 1, 0, "t5_sh5");
    // Extra pattern: 1010 drains 1,0,1,0 then fill zeros, no wrap
    addv(4'b1010, 1, 0, 1, "x_load");
    addv(4'b0000, 0, 1, 0, "x_sh1");
    addv(4'b0000, 0, 1, 1, "x_sh2");
    addv(4'b0000, 0, 1, 0, "x_sh3");
    addv(4'b0000, 0, 1, 0, "x_sh4");
    addv(4'b0000, 0, 1, 0, "x_sh5");

    // Test 1: reset holds out at 0 through edges even with load asserted
    #2;
    check("t1_reset_init", out, 1'b0);
    din = 4'b1111; load = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t1_reset_hold", out, 1'b0);
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Test 6: async reset between edges after loading 1111
    begin
      vec_t v;
      v.din = 4'b1111; v.load = 1; v.shift = 0; v.exp_out = 1; v.name = "t6_load";
      apply(v);
    end
    #2;
    load = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", out, 1'b0);
    @(posedge clk);
    #1;
    check("t6_reset_edge", out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      vec_t v;
      // Word was aborted: shifting after release yields only zeros.
      v.din = 4'b0000; v.load = 0; v.shift = 1; v.exp_out = 0; v.name = "t6_post_sh1";
      apply(v);
      v.name = "t6_post_sh2";
      apply(v);
      v.din = 4'b1001; v.load = 1; v.shift = 0; v.exp_out = 1; v.name = "t6_reload";
      apply(v);
    end

    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
